// File: rtl/spm_arb_pkg.sv
// Shared encodings for the scratch-pad memory arbiter.
// Owner IDs, rw codes and FSM state constants.
package spm_arb_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DBG  = 2'd1,
    OWN_MEM  = 2'd2,
    OWN_IF   = 2'd3
  } owner_e;

  localparam logic [0:0] ST_SHARED   = 1'b0;
  localparam logic [0:0] ST_DBG_LOCK = 1'b1;

  localparam int STARVE_CNT_W = 4;

  function automatic owner_e rd_owner(
    input logic   rw,
    input owner_e id
  );
    return (rw == READ) ? id : OWN_NONE;
  endfunction

endpackage

// File: rtl/spm_arb_if.sv
// Requester-side and SPM-side signals of the SPM arbiter.
// slave = arbiter view, master = requesters plus SPM view.
interface spm_arb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              cpu_en;
  logic              dbg_lock;

  logic              dbg_as_;
  logic              dbg_rw;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rd_data;
  logic              dbg_rd_valid;

  logic              mem_as_;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_stall;

  logic              if_as_;
  logic              if_rw;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rd_data;
  logic              if_rd_valid;
  logic              if_stall;

  logic              spm_as_;
  logic              spm_rw;
  logic [ADDR_W-1:0] spm_addr;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport slave (
    input  cpu_en, dbg_lock,
    input  dbg_as_, dbg_rw, dbg_addr, dbg_wr_data,
    input  mem_as_, mem_rw, mem_addr, mem_wr_data,
    input  if_as_, if_rw, if_addr,
    output dbg_gnt, dbg_rd_data, dbg_rd_valid,
    output mem_gnt, mem_rd_data, mem_rd_valid, mem_stall,
    output if_gnt, if_rd_data, if_rd_valid, if_stall,
    output spm_as_, spm_rw, spm_addr, spm_wr_data,
    input  spm_rd_data
  );

  modport master (
    output cpu_en, dbg_lock,
    output dbg_as_, dbg_rw, dbg_addr, dbg_wr_data,
    output mem_as_, mem_rw, mem_addr, mem_wr_data,
    output if_as_, if_rw, if_addr,
    input  dbg_gnt, dbg_rd_data, dbg_rd_valid,
    input  mem_gnt, mem_rd_data, mem_rd_valid, mem_stall,
    input  if_gnt, if_rd_data, if_rd_valid, if_stall,
    input  spm_as_, spm_rw, spm_addr, spm_wr_data,
    output spm_rd_data
  );

endinterface

// File: rtl/spm_arb_rd_return.sv
// Read-return path: remembers who issued last cycle's read and
// steers spm_rd_data plus a one-cycle valid pulse to that owner.
import spm_arb_pkg::*;

module spm_arb_rd_return #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  owner_e            owner_d,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_rd_valid,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd_valid,
  output logic [DATA_W-1:0] if_rd_data,
  output logic              if_rd_valid
);

  owner_e            owner_q;
  logic [DATA_W-1:0] dbg_hold_q, dbg_hold_d;
  logic [DATA_W-1:0] mem_hold_q, mem_hold_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;

  always_comb begin
    dbg_rd_valid = (owner_q == OWN_DBG);
    mem_rd_valid = (owner_q == OWN_MEM);
    if_rd_valid  = (owner_q == OWN_IF);
    dbg_rd_data  = dbg_rd_valid ? spm_rd_data : dbg_hold_q;
    mem_rd_data  = mem_rd_valid ? spm_rd_data : mem_hold_q;
    if_rd_data   = if_rd_valid  ? spm_rd_data : if_hold_q;
    dbg_hold_d   = dbg_rd_data;
    mem_hold_d   = mem_rd_data;
    if_hold_d    = if_rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      dbg_hold_q <= '0;
      mem_hold_q <= '0;
      if_hold_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      dbg_hold_q <= dbg_hold_d;
      mem_hold_q <= mem_hold_d;
      if_hold_q  <= if_hold_d;
    end
  end

endmodule

// File: rtl/spm_arbiter.sv
// Fixed-priority SPM port arbiter (dbg > mem > if) with debug lock.
// SPM_ARB_STARVE_GUARD_EN adds fetch starvation promotion.
import spm_arb_pkg::*;

module spm_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic     clk,
  input  logic     reset,
  spm_arb_if.slave bus
);

  logic [0:0] state_q, state_d;
  logic       dbg_req, mem_req, if_req;
  logic       cpu_ok, promote;
  logic       dbg_gnt, mem_gnt, if_gnt;
  owner_e     owner_d;

  assign dbg_req = ~bus.dbg_as_;
  assign mem_req = ~bus.mem_as_;
  assign if_req  = ~bus.if_as_;
  assign cpu_ok  = bus.cpu_en && (state_q == ST_SHARED);

`ifdef SPM_ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  assign promote = cpu_ok && (starve_q == STARVE_CNT_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (if_req && starve_q != '1)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  wire unused_starve_max = |STARVE_MAX;
  assign promote = 1'b0;
`endif

  // Grants are forced low while reset is held.
  assign dbg_gnt = reset & dbg_req;
  assign mem_gnt = reset & ~dbg_req & mem_req & cpu_ok
                 & ~(if_req & promote);
  assign if_gnt  = reset & ~dbg_req & if_req & cpu_ok
                 & (~mem_req | promote);

  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.mem_gnt   = mem_gnt;
  assign bus.if_gnt    = if_gnt;
  assign bus.mem_stall = mem_req & ~mem_gnt;
  assign bus.if_stall  = if_req & ~if_gnt;

  always_comb begin
    bus.spm_as_     = 1'b1;
    bus.spm_rw      = 1'b0;
    bus.spm_addr    = '0;
    bus.spm_wr_data = '0;
    owner_d         = OWN_NONE;
    unique case (1'b1)
      dbg_gnt: begin
        bus.spm_as_     = 1'b0;
        bus.spm_rw      = bus.dbg_rw;
        bus.spm_addr    = bus.dbg_addr;
        bus.spm_wr_data = bus.dbg_wr_data;
        owner_d         = rd_owner(bus.dbg_rw, OWN_DBG);
      end
      mem_gnt: begin
        bus.spm_as_     = 1'b0;
        bus.spm_rw      = bus.mem_rw;
        bus.spm_addr    = bus.mem_addr;
        bus.spm_wr_data = bus.mem_wr_data;
        owner_d         = rd_owner(bus.mem_rw, OWN_MEM);
      end
      if_gnt: begin
        bus.spm_as_     = 1'b0;
        bus.spm_rw      = bus.if_rw;
        bus.spm_addr    = bus.if_addr;
        owner_d         = rd_owner(bus.if_rw, OWN_IF);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SHARED:
        if (dbg_gnt && bus.dbg_lock) state_d = ST_DBG_LOCK;
      ST_DBG_LOCK:
        if (!bus.dbg_lock) state_d = ST_SHARED;
      default: state_d = ST_SHARED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_SHARED;
    else        state_q <= state_d;
  end

  spm_arb_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clk          (clk),
    .reset        (reset),
    .owner_d      (owner_d),
    .spm_rd_data  (bus.spm_rd_data),
    .dbg_rd_data  (bus.dbg_rd_data),
    .dbg_rd_valid (bus.dbg_rd_valid),
    .mem_rd_data  (bus.mem_rd_data),
    .mem_rd_valid (bus.mem_rd_valid),
    .if_rd_data   (bus.if_rd_data),
    .if_rd_valid  (bus.if_rd_valid)
  );

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed bench for spm_arbiter with a small behavioural SPM.
// Starvation expectations follow SPM_ARB_STARVE_GUARD_EN.
module tb_spm_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spm_arb_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  spm_arbiter #(
    .ADDR_W     (30),
    .DATA_W     (32),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] spm_mem [0:63];

  always @(posedge clk) begin
    if (!bus.spm_as_) begin
      if (bus.spm_rw) bus.spm_rd_data <= spm_mem[bus.spm_addr[5:0]];
      else            spm_mem[bus.spm_addr[5:0]] <= bus.spm_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_if;
    for (int i = 0; i < 64; i++) spm_mem[i] = 32'hA000_0000 + i;
    bus.spm_rd_data = '0;
    reset = 1'b0;
    bus.cpu_en = 1'b1;  bus.dbg_lock = 1'b0;
    bus.dbg_as_ = 1'b0; bus.dbg_rw = 1'b1;
    bus.dbg_addr = '0;  bus.dbg_wr_data = '0;
    bus.mem_as_ = 1'b1; bus.mem_rw = 1'b1;
    bus.mem_addr = '0;  bus.mem_wr_data = '0;
    bus.if_as_ = 1'b1;  bus.if_rw = 1'b1;
    bus.if_addr = '0;
    #2;
    chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
    chk("rst_spm_as", 32'(bus.spm_as_), 32'd1);
    chk("rst_if_rdv", 32'(bus.if_rd_valid), 32'd0);
    chk("rst_mem_rdd", bus.mem_rd_data, 32'd0);
    bus.dbg_as_ = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // mem write and if read collide: mem first
    bus.if_as_ = 1'b0; bus.if_addr = 30'd0;
    bus.mem_as_ = 1'b0; bus.mem_rw = 1'b0;
    bus.mem_addr = 30'd5; bus.mem_wr_data = 32'h003F8193;
    #1;
    chk("c1_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("c1_if_stall", 32'(bus.if_stall), 32'd1);
    chk("c1_spm_addr", 32'(bus.spm_addr), 32'd5);
    chk("c1_spm_wdata", bus.spm_wr_data, 32'h003F8193);
    tick();
    bus.mem_as_ = 1'b1;
    #1;
    chk("c2_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("c2_mem_rdv", 32'(bus.mem_rd_valid), 32'd0);
    tick();
    bus.if_as_ = 1'b1;
    #1;
    chk("c3_if_rdv", 32'(bus.if_rd_valid), 32'd1);
    chk("c3_if_rdd", bus.if_rd_data, 32'hA0000000);
    chk("c3_spm_as", 32'(bus.spm_as_), 32'd1);
    tick();

    // dbg write beats mem read of the same word
    bus.dbg_as_ = 1'b0; bus.dbg_rw = 1'b0;
    bus.dbg_addr = 30'd4; bus.dbg_wr_data = 32'h00000093;
    bus.mem_as_ = 1'b0; bus.mem_rw = 1'b1; bus.mem_addr = 30'd4;
    #1;
    chk("d1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    chk("d1_mem_stall", 32'(bus.mem_stall), 32'd1);
    chk("d1_if_rdv", 32'(bus.if_rd_valid), 32'd0);
    chk("d1_if_hold", bus.if_rd_data, 32'hA0000000);
    tick();
    bus.dbg_as_ = 1'b1;
    #1;
    chk("d2_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    tick();
    bus.mem_as_ = 1'b1;
    #1;
    chk("d3_mem_rdv", 32'(bus.mem_rd_valid), 32'd1);
    chk("d3_mem_rdd", bus.mem_rd_data, 32'h00000093);
    chk("d3_dbg_rdv", 32'(bus.dbg_rd_valid), 32'd0);

    // dbg lock held three cycles; mem writes word 3 afterwards
    bus.dbg_as_ = 1'b0; bus.dbg_lock = 1'b1; bus.dbg_rw = 1'b0;
    bus.dbg_addr = 30'd10; bus.dbg_wr_data = 32'h55;
    bus.if_as_ = 1'b0; bus.if_addr = 30'd1;
    bus.mem_as_ = 1'b0; bus.mem_rw = 1'b0;
    bus.mem_addr = 30'd3; bus.mem_wr_data = 32'h77;
    #1;
    chk("l1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    chk("l1_cpu_gnt", {30'd0, bus.mem_gnt, bus.if_gnt}, 32'd0);
    tick();
    bus.dbg_as_ = 1'b1;
    #1;
    chk("l2_cpu_gnt", {30'd0, bus.mem_gnt, bus.if_gnt}, 32'd0);
    tick();
    chk("l3_cpu_gnt", {30'd0, bus.mem_gnt, bus.if_gnt}, 32'd0);
    tick();
    bus.dbg_lock = 1'b0;
    #1;
    chk("l4_cpu_gnt", {30'd0, bus.mem_gnt, bus.if_gnt}, 32'd0);
    chk("l4_mem_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    chk("l5_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    tick();

    // cpu_en low: nothing for the CPU, then mem wins
    bus.cpu_en = 1'b0;
    bus.mem_rw = 1'b1; bus.mem_addr = 30'd2;
    #1;
    chk("e1_gnts", {29'd0, bus.dbg_gnt, bus.mem_gnt, bus.if_gnt},
        32'd0);
    chk("e1_spm_as", 32'(bus.spm_as_), 32'd1);
    chk("e1_mem_rdv", 32'(bus.mem_rd_valid), 32'd0);
    tick();
    bus.cpu_en = 1'b1;
    #1;
    chk("e2_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("e2_spm_addr", 32'(bus.spm_addr), 32'd2);
    tick();
    bus.mem_as_ = 1'b1;
    #1;
    chk("e3_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("e3_mem_rdv", 32'(bus.mem_rd_valid), 32'd1);
    chk("e3_mem_rdd", bus.mem_rd_data, 32'hA0000002);
    tick();
    bus.if_addr = 30'd3;
    #1;
    chk("e4_if_rdv", 32'(bus.if_rd_valid), 32'd1);
    chk("e4_if_rdd", bus.if_rd_data, 32'hA0000001);
    chk("e4_mem_hold", bus.mem_rd_data, 32'hA0000002);

    // back-to-back: if reads word 3, then mem reads word 1
    chk("b1_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_as_ = 1'b1;
    bus.mem_as_ = 1'b0; bus.mem_rw = 1'b1; bus.mem_addr = 30'd1;
    #1;
    chk("b2_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    chk("b2_if_rdv", 32'(bus.if_rd_valid), 32'd1);
    chk("b2_if_rdd", bus.if_rd_data, 32'h00000077);
    tick();
    bus.mem_addr = 30'd0;
    #1;
    chk("b3_mem_rdv", 32'(bus.mem_rd_valid), 32'd1);
    chk("b3_mem_rdd", bus.mem_rd_data, 32'hA0000001);
    chk("b3_if_rdv", 32'(bus.if_rd_valid), 32'd0);
    chk("b3_mem_gnt", 32'(bus.mem_gnt), 32'd1);
    tick();

    // cpu_en drops while the mem read of word 0 is returning
    bus.cpu_en = 1'b0; bus.mem_as_ = 1'b1;
    bus.if_as_ = 1'b0; bus.if_addr = 30'd2;
    #1;
    chk("f1_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("f1_if_stall", 32'(bus.if_stall), 32'd1);
    chk("f1_mem_rdv", 32'(bus.mem_rd_valid), 32'd1);
    chk("f1_mem_rdd", bus.mem_rd_data, 32'hA0000000);
    tick();

    // reset lands while an if read is in flight
    bus.cpu_en = 1'b1;
    #1;
    chk("r1_if_gnt", 32'(bus.if_gnt), 32'd1);
    reset = 1'b0;
    tick();
    chk("r2_if_rdv", 32'(bus.if_rd_valid), 32'd0);
    chk("r2_if_rdd", bus.if_rd_data, 32'd0);
    bus.if_as_ = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // mem and if both request continuously
    bus.mem_as_ = 1'b0; bus.mem_rw = 1'b1; bus.mem_addr = 30'd0;
    bus.if_as_ = 1'b0; bus.if_addr = 30'd0;
    for (int k = 1; k <= 12; k++) begin
      #1;
`ifdef SPM_ARB_STARVE_GUARD_EN
      exp_if = (k == 9);
`else
      exp_if = 1'b0;
`endif
      chk($sformatf("s%0d_if_gnt", k), 32'(bus.if_gnt), 32'(exp_if));
      chk($sformatf("s%0d_mem_gnt", k), 32'(bus.mem_gnt),
          32'(!exp_if));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
